// File: rtl/line_xfer_master_if.sv
// AXI-style channel bundles used by line_xfer_master.
//   line_xfer_rd_if : AR (arvalid/arready/araddr/arlen) and R (rvalid/rready/rdata/rresp/rlast)
//   line_xfer_wr_if : AW (awvalid/awready/awaddr/awlen), W (wvalid/wready/wdata/wstrb/wlast)
//                     and B (bvalid/bready/bresp)
// Handshake rule on every channel: a transfer happens on the rising clk edge where
// valid && ready are both high. The master holds its payload stable while valid
// is high and ready is low.

interface line_xfer_rd_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

interface line_xfer_wr_if #(
  parameter int ADDR_WIDTH = 32
) ();
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/line_xfer_master.sv
// line_xfer_master: moves one cache line per request over AXI-style burst
// channels. A fill issues an AR burst of LINE_BEATS beats and collects the R
// beats into a line buffer; a writeback issues an AW burst and streams the
// latched line out on W, then waits for B. Each request ends with a one-cycle
// resp_valid pulse carrying the fill data and an error flag.
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   req_valid/ready  : request handshake (ready only in IDLE)
//   req_write        : 1 = writeback, 0 = fill
//   req_addr         : line address, bits [1:0] ignored
//   req_wdata        : writeback line, beat i at [i*32 +: 32]
//   resp_valid       : one-cycle completion pulse
//   resp_rdata       : last completed fill line (kept across writebacks)
//   resp_err         : transaction error flag, meaningful with resp_valid
//   axi_read_if      : AR/R master channels
//   axi_write_if     : AW/W/B master channels
//   perf_*_cnt       : 32-bit event counters, present only when the macro
//                      LINE_XFER_PERF_EN is defined
//   dbg_state        : current FSM state encoding
//
// Handshakes: every valid/ready pair transfers on a rising edge with both
// high; payloads are held stable from valid until that edge.

module line_xfer_master #(
  parameter int LINE_BEATS = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  input  logic [LINE_BEATS*32-1:0]   req_wdata,
  output logic                       resp_valid,
  output logic [LINE_BEATS*32-1:0]   resp_rdata,
  output logic                       resp_err,
  line_xfer_rd_if.master             axi_read_if,
  line_xfer_wr_if.master             axi_write_if,
`ifdef LINE_XFER_PERF_EN
  output logic [31:0]                perf_fill_cnt,
  output logic [31:0]                perf_wb_cnt,
  output logic [31:0]                perf_stall_cnt,
`endif
  output logic [2:0]                 dbg_state
);

  localparam int BW = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_BEATS - 1);
  localparam logic [7:0]    BURST_LEN = 8'(LINE_BEATS - 1);
  localparam int LW = LINE_BEATS * 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_RESP = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  // Set once the last in-range R beat is stored; later beats are dropped.
  logic                    full_q, full_d;
  logic [ADDR_WIDTH-1:2]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic [LW-1:0]           line_buf_q, line_buf_d;
  logic [LW-1:0]           rdata_q, rdata_d;

  logic                    ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic [BW+4:0]           beat_off;

  logic                    unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  assign beat_off = {beat_q, 5'd0};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      full_q     <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      line_buf_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      full_q     <= full_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      err_q      <= err_d;
      line_buf_q <= line_buf_d;
      rdata_q    <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and channel controls
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    full_d     = full_q;
    addr_d     = addr_q;
    write_d    = write_q;
    err_d      = err_q;
    line_buf_d = line_buf_q;
    rdata_d    = rdata_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    b_ready    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr[ADDR_WIDTH-1:2];
          write_d = req_write;
          err_d   = 1'b0;
          beat_d  = '0;
          full_d  = 1'b0;
          if (req_write) begin
            line_buf_d = req_wdata;
            state_d    = S_AW;
          end else begin
            state_d    = S_AR;
          end
        end
      end

      S_AR: begin
        ar_valid = 1'b1;
        if (axi_read_if.arready) state_d = S_R;
      end

      S_R: begin
        r_ready = 1'b1;
        if (axi_read_if.rvalid) begin
          if (!full_q) begin
            line_buf_d[beat_off +: 32] = axi_read_if.rdata;
            if (beat_q == LAST_BEAT) full_d = 1'b1;
            else                     beat_d = beat_q + 1'b1;
          end
          // Any beat past the end of the line is an error, as is a burst
          // that terminates before the last beat.
          err_d = err_q | (axi_read_if.rresp != 2'b00) | full_q |
                  (axi_read_if.rlast & (beat_q != LAST_BEAT));
          if (axi_read_if.rlast) begin
            // Capture the merged buffer so resp_rdata is valid during RESP.
            rdata_d = line_buf_d;
            state_d = S_RESP;
          end
        end
      end

      S_AW: begin
        aw_valid = 1'b1;
        if (axi_write_if.awready) state_d = S_W;
      end

      S_W: begin
        w_valid = 1'b1;
        if (axi_write_if.wready) begin
          if (beat_q == LAST_BEAT) state_d = S_B;
          else                     beat_d  = beat_q + 1'b1;
        end
      end

      S_B: begin
        b_ready = 1'b1;
        if (axi_write_if.bvalid) begin
          err_d   = err_q | (axi_write_if.bresp != 2'b00);
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. Address/length come straight from latched registers so they stay
  // stable for the whole burst.
  // ---------------------------------------------------------------------------
  assign axi_read_if.arvalid  = ar_valid;
  assign axi_read_if.araddr   = {addr_q, 2'b00};
  assign axi_read_if.arlen    = BURST_LEN;
  assign axi_read_if.rready   = r_ready;

  assign axi_write_if.awvalid = aw_valid;
  assign axi_write_if.awaddr  = {addr_q, 2'b00};
  assign axi_write_if.awlen   = BURST_LEN;
  assign axi_write_if.wvalid  = w_valid;
  assign axi_write_if.wdata   = line_buf_q[beat_off +: 32];
  assign axi_write_if.wstrb   = 4'hF;
  assign axi_write_if.wlast   = (state_q == S_W) && (beat_q == LAST_BEAT);
  assign axi_write_if.bready  = b_ready;

  assign resp_rdata = rdata_q;
  assign resp_err   = (state_q == S_RESP) && err_q;
  assign dbg_state  = state_q;

`ifdef LINE_XFER_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic        stall;
  logic [31:0] fill_cnt_q, wb_cnt_q, stall_cnt_q;

  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_AR:    stall = !axi_read_if.arready;
      S_R:     stall = !axi_read_if.rvalid;
      S_AW:    stall = !axi_write_if.awready;
      S_W:     stall = !axi_write_if.wready;
      S_B:     stall = !axi_write_if.bvalid;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_q  <= '0;
      wb_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == S_RESP) begin
        if (write_q) wb_cnt_q   <= wb_cnt_q + 32'd1;
        else         fill_cnt_q <= fill_cnt_q + 32'd1;
      end
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fill_cnt  = fill_cnt_q;
  assign perf_wb_cnt    = wb_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_line_xfer_master.sv
// Directed bench for line_xfer_master: a table of line transactions driven
// through a simple AXI slave, plus hand-written backpressure/reset and
// performance-counter sequences.

module tb_line_xfer_master;

  localparam int LB = 8;
  localparam int AW = 32;
  localparam int LW = LB * 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr  = '0;
  logic [LW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [LW-1:0] resp_rdata;
  logic          resp_err;
  logic [2:0]    dbg_state;
`ifdef LINE_XFER_PERF_EN
  logic [31:0]   perf_fill_cnt, perf_wb_cnt, perf_stall_cnt;
`endif

  line_xfer_rd_if #(.ADDR_WIDTH(AW)) rd_if ();
  line_xfer_wr_if #(.ADDR_WIDTH(AW)) wr_if ();

  line_xfer_master #(.LINE_BEATS(LB), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .axi_read_if  (rd_if),
    .axi_write_if (wr_if),
`ifdef LINE_XFER_PERF_EN
    .perf_fill_cnt  (perf_fill_cnt),
    .perf_wb_cnt    (perf_wb_cnt),
    .perf_stall_cnt (perf_stall_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [LW-1:0] last_fill = '0;
  bit rdata_known = 1'b1;
  int exp_stall = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Only one burst direction may be active at a time.
  always @(negedge clk) begin
    if (!rst) check("ar_aw_excl", {255'd0, rd_if.arvalid & wr_if.awvalid}, '0);
  end

  // ---------------------------------------------------------------------------
  // Transaction table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] base;
    logic [31:0] stp;
    int          err_beat;    // fill: SLVERR on this beat; wb: >=0 gives SLVERR bresp
    int          early_last;  // fill: rlast on this beat (-1 = normal)
    int          extra;       // fill: beats sent beyond the line
    int          delay;       // cycles before arready/awready and bvalid
    logic [31:0] exp_addr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    logic [LW-1:0] line;
    logic [31:0]   exp_w;
    int            nb;
    for (int i = 0; i < LB; i++) line[i*32 +: 32] = v.base + v.stp * i;
    req_addr  = v.addr;
    req_write = v.wr;
    req_wdata = v.wr ? line : {LB{32'hDEAD_BEEF}};
    req_valid = 1'b1;
    check("req_ready_idle", {255'd0, req_ready}, 1);
    step();
    req_valid = 1'b0;
    check("req_ready_busy", {255'd0, req_ready}, 0);
    if (!v.wr) begin
      for (int c = 0; c < v.delay; c++) begin
        check("arvalid_wait", {255'd0, rd_if.arvalid}, 1);
        step();
      end
      check("arvalid", {255'd0, rd_if.arvalid}, 1);
      check("araddr", {224'd0, rd_if.araddr}, {224'd0, v.exp_addr});
      check("arlen", {248'd0, rd_if.arlen}, 7);
      rd_if.arready = 1'b1;
      step();
      rd_if.arready = 1'b0;
      nb = (v.early_last >= 0) ? v.early_last + 1 : LB + v.extra;
      for (int b = 0; b < nb; b++) begin
        check("rready", {255'd0, rd_if.rready}, 1);
        check("araddr_hold", {224'd0, rd_if.araddr}, {224'd0, v.exp_addr});
        rd_if.rvalid = 1'b1;
        rd_if.rdata  = v.base + v.stp * b;
        rd_if.rresp  = (b == v.err_beat) ? 2'b10 : 2'b00;
        rd_if.rlast  = (b == nb - 1);
        step();
      end
      rd_if.rvalid = 1'b0;
      rd_if.rlast  = 1'b0;
      rd_if.rresp  = 2'b00;
      exp_stall += v.delay;
    end else begin
      for (int c = 0; c < v.delay; c++) begin
        check("awvalid_wait", {255'd0, wr_if.awvalid}, 1);
        check("wvalid_pre_aw", {255'd0, wr_if.wvalid}, 0);
        step();
      end
      check("awaddr", {224'd0, wr_if.awaddr}, {224'd0, v.exp_addr});
      check("awlen", {248'd0, wr_if.awlen}, 7);
      check("wvalid_pre_aw", {255'd0, wr_if.wvalid}, 0);
      wr_if.awready = 1'b1;
      step();
      wr_if.awready = 1'b0;
      for (int b = 0; b < LB; b++) exp_q.push_back(line[b*32 +: 32]);
      wr_if.wready = 1'b1;
      for (int b = 0; b < LB; b++) begin
        exp_w = exp_q.pop_front();
        check("wvalid", {255'd0, wr_if.wvalid}, 1);
        check("wdata", {224'd0, wr_if.wdata}, {224'd0, exp_w});
        check("wstrb", {252'd0, wr_if.wstrb}, 4'hF);
        check("wlast", {255'd0, wr_if.wlast}, (b == LB - 1) ? 1 : 0);
        step();
      end
      wr_if.wready = 1'b0;
      for (int c = 0; c < v.delay; c++) begin
        check("bready", {255'd0, wr_if.bready}, 1);
        check("resp_before_b", {255'd0, resp_valid}, 0);
        step();
      end
      wr_if.bvalid = 1'b1;
      wr_if.bresp  = (v.err_beat >= 0) ? 2'b10 : 2'b00;
      step();
      wr_if.bvalid = 1'b0;
      wr_if.bresp  = 2'b00;
      exp_stall += 2 * v.delay;
    end
    check("resp_valid", {255'd0, resp_valid}, 1);
    check("resp_err", {255'd0, resp_err}, {255'd0, v.exp_err});
    if (!v.wr) begin
      if (v.early_last < 0) check("resp_rdata", resp_rdata, line);
      rdata_known = (v.early_last < 0);
      last_fill   = line;
    end else if (rdata_known) begin
      check("rdata_kept", resp_rdata, last_fill);
    end
    step();
    check("resp_pulse_end", {255'd0, resp_valid}, 0);
    check("req_ready_after", {255'd0, req_ready}, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  logic [LW-1:0] bp_line;
  int beats;
  int cyc;

  initial begin
    rd_if.arready = 1'b0; rd_if.rvalid = 1'b0; rd_if.rdata = '0;
    rd_if.rresp   = 2'b00; rd_if.rlast = 1'b0;
    wr_if.awready = 1'b0; wr_if.wready = 1'b0; wr_if.bvalid = 1'b0;
    wr_if.bresp   = 2'b00;

    //          wr    addr           base           stp          eb  el ex d  exp_addr       err
    vecs[0] = '{1'b0, 32'h0000_1043, 32'h11,        32'h11,      -1, -1, 0, 0, 32'h0000_1040, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0200, 32'hA0,        32'h1,       -1, -1, 0, 2, 32'h0000_0200, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_3000, 32'h100,       32'h10,       3, -1, 0, 1, 32'h0000_3000, 1'b1};
    vecs[3] = '{1'b1, 32'h0000_5006, 32'hB000,      32'h3,        0, -1, 0, 0, 32'h0000_5004, 1'b1};
    vecs[4] = '{1'b0, 32'h0000_6FFD, 32'hCAFE_0000, 32'h7,       -1, -1, 0, 3, 32'h0000_6FFC, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_7000, 32'h500,       32'h1,       -1, -1, 1, 0, 32'h0000_7000, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_4008, 32'h900,       32'h1,       -1,  5, 0, 0, 32'h0000_4008, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_9000, 32'h1234,      32'h1111,    -1, -1, 0, 1, 32'h0000_9000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req_ready", {255'd0, req_ready}, 1);
    check("rst_resp_valid", {255'd0, resp_valid}, 0);
    check("rst_resp_err", {255'd0, resp_err}, 0);
    check("rst_resp_rdata", resp_rdata, '0);
    check("rst_arvalid", {255'd0, rd_if.arvalid}, 0);
    check("rst_rready", {255'd0, rd_if.rready}, 0);
    check("rst_awvalid", {255'd0, wr_if.awvalid}, 0);
    check("rst_wvalid", {255'd0, wr_if.wvalid}, 0);
    check("rst_bready", {255'd0, wr_if.bready}, 0);
    check("rst_state", {253'd0, dbg_state}, 0);

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Backpressure on AW and W, then reset in the middle of W beat 4.
    for (int i = 0; i < LB; i++) bp_line[i*32 +: 32] = 32'h7700_0000 + 32'(i * 5);
    req_addr  = 32'h0000_0802;
    req_write = 1'b1;
    req_wdata = bp_line;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("bp_awvalid", {255'd0, wr_if.awvalid}, 1);
      check("bp_awaddr", {224'd0, wr_if.awaddr}, 32'h0000_0800);
      check("bp_awlen", {248'd0, wr_if.awlen}, 7);
      check("bp_wvalid_pre_aw", {255'd0, wr_if.wvalid}, 0);
      step();
    end
    wr_if.awready = 1'b1;
    step();
    wr_if.awready = 1'b0;
    beats = 0;
    cyc   = 0;
    while (beats < 4 && cyc < 40) begin
      wr_if.wready = (cyc % 2 == 1);
      check("bp_wvalid", {255'd0, wr_if.wvalid}, 1);
      check("bp_wdata", {224'd0, wr_if.wdata}, {224'd0, bp_line[beats*32 +: 32]});
      check("bp_awaddr_hold", {224'd0, wr_if.awaddr}, 32'h0000_0800);
      step();
      if (wr_if.wready) beats++;
      cyc++;
    end
    wr_if.wready = 1'b0;
    check("bp_beat4_reached", {224'd0, 32'(beats)}, 4);
    check("bp_wdata_beat4", {224'd0, wr_if.wdata}, {224'd0, bp_line[4*32 +: 32]});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state", {253'd0, dbg_state}, 0);
    check("mid_rst_req_ready", {255'd0, req_ready}, 1);
    check("mid_rst_wvalid", {255'd0, wr_if.wvalid}, 0);
    check("mid_rst_rdata", resp_rdata, '0);
    for (int c = 0; c < 4; c++) begin
      check("mid_rst_no_resp", {255'd0, resp_valid}, 0);
      step();
    end

`ifdef LINE_XFER_PERF_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("perf_rst_stall", {224'd0, perf_stall_cnt}, 0);
    exp_stall = 0;
    rdata_known = 1'b0;
    run_vec('{1'b0, 32'h0000_A000, 32'h10, 32'h1, -1, -1, 0, 10, 32'h0000_A000, 1'b0});
    run_vec('{1'b1, 32'h0000_B000, 32'h20, 32'h1, -1, -1, 0, 10, 32'h0000_B000, 1'b0});
    run_vec('{1'b0, 32'h0000_C000, 32'h30, 32'h1, -1, -1, 0, 10, 32'h0000_C000, 1'b0});
    check("perf_fill_cnt", {224'd0, perf_fill_cnt}, 2);
    check("perf_wb_cnt", {224'd0, perf_wb_cnt}, 1);
    check("perf_stall_cnt", {224'd0, perf_stall_cnt}, {224'd0, 32'(exp_stall)});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
